// File: rtl/afpm_pkg.sv
// Shared constants and types for the logarithmic FP16 multiplier tile.
// Latency: none (declarations only).
// Backpressure: none.
package afpm_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'd31;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  // One state per byte slot of the repeating four-cycle frame
  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_HI   = 2'd1,
    S_CALC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

endpackage

// File: rtl/lmul_fp16.sv
// Approximate FP16 multiply: adds exponent/mantissa as log2 values (Mitchell).
// Latency: purely combinational.
// Backpressure: none.
module lmul_fp16
  import afpm_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] r
);

  logic             sa, sb, sign;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MAN_W:0]   m_sum;
  logic signed [7:0] e_sum;

  assign sa = a[15];
  assign sb = b[15];
  assign ea = a[14:10];
  assign eb = b[14:10];
  assign ma = a[9:0];
  assign mb = b[9:0];
  assign sign = sa ^ sb;

  assign a_nan  = (ea == EXP_MAX) && (ma != '0);
  assign b_nan  = (eb == EXP_MAX) && (mb != '0);
  assign a_inf  = (ea == EXP_MAX) && (ma == '0);
  assign b_inf  = (eb == EXP_MAX) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  // Mantissa fractions add in the log domain; carry out bumps the exponent
  assign m_sum = {1'b0, ma} + {1'b0, mb};
  assign e_sum = $signed({3'b000, ea}) + $signed({3'b000, eb})
               + $signed({7'b0000000, m_sum[MAN_W]}) - 8'sd15;

  // Special-case priority: NaN/invalid, then Inf, then zero, then range clamp
  always_comb begin
    r = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = QNAN;
    end else if (a_inf || b_inf) begin
      r = {sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      r = {sign, 15'h0000};
    end else if (e_sum >= 8'sd31) begin
      r = {sign, EXP_MAX, {MAN_W{1'b0}}};
    end else if (e_sum <= 8'sd0) begin
      r = {sign, 15'h0000};
    end else begin
      r = {sign, e_sum[EXP_W-1:0], m_sum[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/tt_um_logarithmic_afpm.sv
// Tiny Tapeout tile: byte-serial operands in, byte-serial approximate FP16 product out.
// Latency: low result byte 1 cycle after the high-operand edge, high byte 1 cycle later.
// Backpressure: none; the four-cycle frame free-runs and inputs are sampled unconditionally.
module tt_um_logarithmic_afpm
  import afpm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t      state;
  logic [15:0] a, b;
  logic [15:0] r;
  logic [7:0]  res_hi;

  // The tile runs whenever clocked, so enable carries no meaning here
  logic unused_ena;
  assign unused_ena = &{1'b0, ena};

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  lmul_fp16 u_lmul (
    .a (a),
    .b (b),
    .r (r)
  );

  // Frame sequencer: capture low/high operand bytes, then emit low/high result bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_LO;
      a      <= '0;
      b      <= '0;
      res_hi <= '0;
      uo_out <= '0;
    end else begin
      case (state)
        S_LO: begin
          a[7:0] <= ui_in;
          b[7:0] <= uio_in;
          state  <= S_HI;
        end
        S_HI: begin
          a[15:8] <= ui_in;
          b[15:8] <= uio_in;
          state   <= S_CALC;
        end
        S_CALC: begin
          uo_out <= r[7:0];
          res_hi <= r[15:8];
          state  <= S_OUT;
        end
        default: begin
          uo_out <= res_hi;
          state  <= S_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_logarithmic_afpm.sv
module tb_tt_um_logarithmic_afpm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uio_in;
  logic [7:0] uo_out, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  int          edges = 0;
  logic [7:0]  got_lo = 8'h00;
  logic [7:0]  last_hi = 8'h00;

  tt_um_logarithmic_afpm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Reference: value = 2^(e-15) * (1 + m/1024); multiplying adds logs,
  // log2 taken as (e-15) + m/1024, kept in units of 1/1024.
  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, l, e, m;
    logic s;
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    nan_a = (ea == 31) && (ma != 0); nan_b = (eb == 31) && (mb != 0);
    inf_a = (ea == 31) && (ma == 0); inf_b = (eb == 31) && (mb == 0);
    z_a = (ea == 0); z_b = (eb == 0);
    if (nan_a || nan_b || (inf_a && z_b) || (inf_b && z_a)) return 16'h7E00;
    if (inf_a || inf_b) return {s, 15'h7C00};
    if (z_a || z_b) return {s, 15'h0000};
    l = (ea - 15 + eb - 15) * 1024 + ma + mb + 30 * 1024;  // offset keeps l >= 0
    e = l / 1024 - 15;
    m = l % 1024;
    if (e >= 31) return {s, 15'h7C00};
    if (e <= 0) return {s, 15'h0000};
    return {s, 5'(e), 10'(m)};
  endfunction

  // Frame position tracker; reset aborts the frame and discards pending results
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges   = 0;
      got_lo  = 8'h00;
      last_hi = 8'h00;
      exp_q.delete();
    end else begin
      edges = edges + 1;
    end
  end

  // Monitor: sample away from the active edge according to the frame slot just entered
  always @(negedge clk) begin
    if (rst_n && edges > 0) begin
      case ((edges - 1) % 4)
        0, 1: chk("hold", {8'h00, uo_out}, {8'h00, last_hi});
        2:    got_lo = uo_out;
        default: begin
          last_hi = uo_out;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", {uo_out, got_lo}, 16'hxxxx);
          end else begin
            chk("result", {uo_out, got_lo}, exp_q.pop_front());
          end
          chk("uio_pins", {uio_out, uio_oe}, 16'h0000);
        end
      endcase
    end
  end

  // Drives one frame; must be called with the next rising edge being an S_LO edge
  task automatic send(input logic [15:0] a, input logic [15:0] b);
    ena    = 1'($urandom_range(0, 1));
    ui_in  = a[7:0];
    uio_in = b[7:0];
    @(posedge clk); #1;
    ena    = 1'($urandom_range(0, 1));
    ui_in  = a[15:8];
    uio_in = b[15:8];
    @(posedge clk);
    exp_q.push_back(model(a, b));
    #1;
    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    ena    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  logic [15:0] dir_a[] = '{16'h3E00, 16'h3C00, 16'h4000, 16'h7800, 16'h0400,
                           16'h0000, 16'h7E00, 16'h7C00, 16'h4A00, 16'hBC00};
  logic [15:0] dir_b[] = '{16'h4200, 16'h3C00, 16'hC200, 16'h7800, 16'h0400,
                           16'hC200, 16'h3C00, 16'h0000, 16'h4D00, 16'hFC00};

  initial begin
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    #1;
    chk("reset_uo_out", {8'h00, uo_out}, 16'h0000);
    chk("reset_uio", {uio_out, uio_oe}, 16'h0000);
    // spot-check the reference against hand-derived products
    chk("model_1p5x3", model(16'h3E00, 16'h4200), 16'h4400);
    chk("model_2xm3", model(16'h4000, 16'hC200), 16'hC600);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back directed frames
    foreach (dir_a[i]) send(dir_a[i], dir_b[i]);

    // Abort a frame between the high-operand and compute edges
    ui_in = 8'h00; uio_in = 8'h00;
    @(posedge clk); #1;
    ui_in = 8'h40; uio_in = 8'h40;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset_uo_out", {8'h00, uo_out}, 16'h0000);
    chk("midframe_reset_uio", {uio_out, uio_oe}, 16'h0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    send(16'h3C00, 16'h4000);

    // Randomized frames, mostly normal numbers with occasional raw patterns
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 != 0) begin
        ra[14:10] = 5'($urandom_range(1, 30));
        rb[14:10] = 5'($urandom_range(1, 30));
      end
      send(ra, rb);
    end

    @(negedge clk); #1;
    chk("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
